// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped I/O port sitting behind the CPU core.
// OUT writes are pushed into an output FIFO that a peripheral drains over
// valid/ready. IN reads are served from a one-byte holding register. The
// bus stays undriven until that register holds a byte, so the core stalls.
//
// Read FSM states:
//   state | meaning
//   IDLE  | no read in progress
//   WAIT  | read strobe high, holding register empty, bus released
//   DRIVE | read strobe high, hold byte on the bus until the strobe drops
module io_port_ctrl #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] PORT_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr_bus,
    input  logic       c_ri,
    input  logic       c_ro,
    input  logic       mem_io,
    inout  wire  [7:0] bus,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_full,
    output logic       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state, state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [7:0]    head_nxt;

    logic          sel, wr, rd, wr_d, cap;
    logic          push, pop;
    logic          hold_valid;
    logic [7:0]    hold_data;
    logic          consume, drive_en;

    // Strobe decode, capture edge and FIFO next-state arithmetic.
    always_comb begin
        sel      = mem_io && (addr_bus == PORT_ADDR);
        wr       = sel && c_ri && !c_ro;
        rd       = sel && c_ro && !c_ri;
        cap      = wr && !wr_d;
        pop      = out_valid && out_ready;
        push     = cap && ((count < DEPTH_C) || pop);

        rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase

        // The next head is the incoming byte when it lands exactly at the new
        // read pointer (empty FIFO, or last entry popped while pushing).
        if (push && (wr_ptr == rd_ptr_nxt))
            head_nxt = bus;
        else
            head_nxt = mem[rd_ptr_nxt];
    end

    assign out_valid = (count != '0);
    assign out_full  = (count == DEPTH_C);
    assign in_ready  = !hold_valid;

    // Registered strobe; tracking wr through reset means a strobe still high
    // when reset releases is not seen as a fresh edge.
    always_ff @(posedge clk) begin
        wr_d <= wr;
    end

    // FIFO storage; no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem[wr_ptr] <= bus;
    end

    // FIFO pointers, count, registered head and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= 8'h00;
            ovf      <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0)
                out_data <= head_nxt;
            if (cap && !push)
                ovf <= 1'b1;
        end
    end

    // Input holding register: load on handshake, clear once the byte is read.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
        end else if (in_valid && in_ready) begin
            hold_valid <= 1'b1;
            hold_data  <= in_data;
        end else if (consume) begin
            hold_valid <= 1'b0;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Read FSM next state; a byte is consumed only on leaving DRIVE.
    always_comb begin
        state_nxt = state;
        consume   = 1'b0;
        case (state)
            IDLE: begin
                if (rd && hold_valid)
                    state_nxt = DRIVE;
                else if (rd)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (!rd)
                    state_nxt = IDLE;
                else if (hold_valid)
                    state_nxt = DRIVE;
            end
            DRIVE: begin
                if (!rd) begin
                    state_nxt = IDLE;
                    consume   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign drive_en = (state == DRIVE) && rd && !reset;
    assign bus      = drive_en ? hold_data : 8'hzz;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Testbench for io_port_ctrl: queue-based reference model with a scoreboard
// monitor comparing popped bytes and the FIFO status flags.
module tb_io_port_ctrl;

    localparam int         DEPTH = 8;
    localparam logic [7:0] PORT  = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr_bus;
    logic       c_ri, c_ro, mem_io;
    wire  [7:0] bus;
    logic [7:0] tb_bus;
    logic       tb_bus_en;
    logic [7:0] out_data;
    logic       out_valid, out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready, out_full, ovf;

    assign bus = tb_bus_en ? tb_bus : 8'hzz;

    always #5 clk = ~clk;

    io_port_ctrl #(.DEPTH(DEPTH), .PORT_ADDR(PORT)) dut (
        .clk(clk), .reset(reset), .addr_bus(addr_bus), .c_ri(c_ri), .c_ro(c_ro),
        .mem_io(mem_io), .bus(bus), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_full(out_full), .ovf(ovf)
    );

    int         n_checks = 0;
    int         n_pass   = 0;

    logic [7:0] mq[$];      // model FIFO contents
    logic [7:0] sb[$];      // bytes the peripheral should receive, in order
    logic       m_ovf      = 1'b0;
    logic       m_wr_prev  = 1'b0;
    logic       exp_valid  = 1'b0;
    logic       exp_full   = 1'b0;
    logic       exp_ovf    = 1'b0;
    bit         mon_en     = 1'b0;
    bit         rand_ready = 1'b0;
    logic [7:0] s_bus;
    logic       s_in_ready;

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    // An undriven bus reads as Z in a 4-state simulator and 0 in a 2-state one.
    task automatic check_released(input string name);
        n_checks++;
        if (s_bus === 8'hzz || s_bus === 8'h00) n_pass++;
        else $display("FAIL %s: bus %02h expected released", name, s_bus);
    endtask

    // One clock cycle: record expectations for the current state, advance the
    // model across the coming edge, sample bus just before the edge.
    task automatic tick();
        logic wr_now;
        logic pop;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        exp_valid = (mq.size() > 0);
        exp_full  = (mq.size() == DEPTH);
        exp_ovf   = m_ovf;
        wr_now = mem_io && (addr_bus == PORT) && c_ri && !c_ro;
        if (reset) begin
            mq.delete();
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            pop = (mq.size() > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (wr_now && !m_wr_prev) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(tb_bus);
                    sb.push_back(tb_bus);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        m_wr_prev = wr_now;
        #4;
        s_bus      = bus;
        s_in_ready = in_ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Scoreboard monitor: status flags every cycle, data on every pop.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            check1("out_valid", out_valid, exp_valid);
            check1("out_full", out_full, exp_full);
            check1("ovf", ovf, exp_ovf);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL pop_unexpected: out_data %02h popped, expected no byte", out_data);
                end else begin
                    check8("out_data", out_data, sb.pop_front());
                end
            end
        end
    end

    task automatic idle_bus();
        mem_io    = 1'b0;
        c_ri      = 1'b0;
        c_ro      = 1'b0;
        tb_bus_en = 1'b0;
        addr_bus  = PORT;
    endtask

    task automatic out_write(input logic [7:0] b, input int len, input logic [7:0] a,
                             input bit ready_first);
        addr_bus  = a;
        mem_io    = 1'b1;
        c_ri      = 1'b1;
        c_ro      = 1'b0;
        tb_bus    = b;
        tb_bus_en = 1'b1;
        for (int i = 0; i < len; i++) begin
            if (ready_first) out_ready = (i == 0);
            tick();
        end
        idle_bus();
        tick();
    endtask

    task automatic start_read();
        addr_bus  = PORT;
        mem_io    = 1'b1;
        c_ri      = 1'b0;
        c_ro      = 1'b1;
        tb_bus_en = 1'b0;
    endtask

    task automatic offer(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic rd_wait_drive(input logic [7:0] b, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (s_bus === b) got = 1'b1;
        end
        n_checks++;
        if (got) n_pass++;
        else $display("FAIL %s: bus %02h never reached %02h", name, s_bus, b);
    endtask

    task automatic rd_end(input string name);
        idle_bus();
        tick();
        check_released({name, "_release"});
        check1({name, "_in_ready_low"}, s_in_ready, 1'b0);
        tick();
        check1({name, "_in_ready_high"}, s_in_ready, 1'b1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tb_bus = 8'h00;
        idle_bus();
        tick();
        mon_en = 1'b1;
        do_reset(2);

        // Reset state
        check8("rst_out_data", out_data, 8'h00);
        check1("rst_in_ready", in_ready, 1'b1);
        tick();
        check_released("rst_bus");

        // Single OUT, strobe held 3 clocks
        out_write(8'hA5, 3, PORT, 1'b0);
        check1("single_valid", out_valid, 1'b1);
        check8("single_data", out_data, 8'hA5);
        out_ready = 1'b1;
        tick(); tick();
        check1("single_drained", out_valid, 1'b0);

        // Nine OUTs into an 8-deep FIFO, then drain
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) out_write(8'(i), 2 + (i % 3), PORT, 1'b0);
        check1("fill_full", out_full, 1'b1);
        check1("fill_ovf", ovf, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check1("fill_empty", out_valid, 1'b0);
        check1("fill_ovf_sticky", ovf, 1'b1);

        // Full FIFO, push coinciding with a pop
        do_reset(2);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) out_write(8'h11 + 8'(i), 2, PORT, 1'b0);
        check1("coin_full_before", out_full, 1'b1);
        out_write(8'h0A, 3, PORT, 1'b1);
        check1("coin_full_after", out_full, 1'b1);
        check1("coin_ovf", ovf, 1'b0);
        check8("coin_head", out_data, 8'h12);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        // IN read with empty holding register
        start_read();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_released("wait_bus");
            check1("wait_in_ready", s_in_ready, 1'b1);
        end
        offer(8'h3C);
        rd_wait_drive(8'h3C, "wait_drive");
        tick();
        check8("drive_hold", s_bus, 8'h3C);
        rd_end("rd1");

        // Aborted read keeps the later byte for the next read
        start_read();
        tick(); tick(); tick();
        idle_bus();
        tick();
        offer(8'hC3);
        tick();
        check1("abort_in_ready", s_in_ready, 1'b0);
        start_read();
        rd_wait_drive(8'hC3, "abort_drive");
        rd_end("rd2");

        // Strobe conflict and address mismatch
        offer(8'h5A);
        mem_io = 1'b1; c_ri = 1'b1; c_ro = 1'b1; addr_bus = PORT; tb_bus_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_released("conflict_bus");
        end
        idle_bus();
        tick();
        check1("conflict_no_push", out_valid, 1'b0);
        check1("conflict_hold_kept", in_ready, 1'b0);
        out_write(8'h77, 3, 8'h01, 1'b0);
        check1("addr_no_push", out_valid, 1'b0);
        start_read();
        rd_wait_drive(8'h5A, "conflict_drive");
        rd_end("rd3");

        // Reset during DRIVE with three bytes queued
        out_ready = 1'b0;
        out_write(8'h21, 2, PORT, 1'b0);
        out_write(8'h22, 2, PORT, 1'b0);
        out_write(8'h23, 2, PORT, 1'b0);
        offer(8'h99);
        start_read();
        rd_wait_drive(8'h99, "rst_drive");
        reset = 1'b1;
        tick();
        check_released("rst_mid_bus");
        reset = 1'b0;
        check1("rst_mid_valid", out_valid, 1'b0);
        check1("rst_mid_in_ready", in_ready, 1'b1);
        check1("rst_mid_ovf", ovf, 1'b0);
        tick();
        check_released("rst_mid_idle_bus");
        idle_bus();
        tick();

        // Write strobe held across reset release is not captured
        mem_io = 1'b1; c_ri = 1'b1; c_ro = 1'b0; addr_bus = PORT;
        tb_bus = 8'hEE; tb_bus_en = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        idle_bus();
        tick();
        check1("wr_across_reset", out_valid, 1'b0);

        // Randomized OUT traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            out_write(8'($urandom), int'($urandom_range(1, 4)),
                      ($urandom_range(0, 7) == 0) ? 8'h01 : PORT, 1'b0);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check1("rand_drained", out_valid, 1'b0);

        // Randomized IN reads, data-first or read-first
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = 8'($urandom) | 8'h01;
            if ($urandom_range(0, 1) == 1) begin
                offer(b);
                tick();
                start_read();
            end else begin
                start_read();
                for (int j = 0; j < int'($urandom_range(1, 4)); j++) tick();
                offer(b);
            end
            rd_wait_drive(b, "rand_rd");
            rd_end("rand_rd");
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
